// File: rtl/imem_arb_pkg.sv
// -----------------------------------------------------------------------------
// imem_arb_pkg
// Shared definitions for the instruction-memory port arbiter.
//   state_t : arbiter FSM encoding (S_FETCH = normal arbitration, S_LOAD =
//             port locked to an in-progress loader burst)
//   gnt_t   : which requester owns the memory port in the current cycle
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
// -----------------------------------------------------------------------------
package imem_arb_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_LOAD  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_FE   = 2'd1,
      GNT_LD   = 2'd2,
      GNT_DBG  = 2'd3
   } gnt_t;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// imem_arb_starve_ctr
// Saturating count of consecutive cycles in which a pending loader/debug
// request lost the port to fetch. Once the count reaches MAX_WAIT the
// 'starved' flag tells the arbiter to deny fetch in favour of the waiting
// requester. MAX_WAIT must be at least 1.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-low reset (count -> 0)
//   inc     in  fetch won while another requester was pending
//   clr     in  another requester was served, or nothing else is pending
//   starved out count has reached MAX_WAIT
// -----------------------------------------------------------------------------
module imem_arb_starve_ctr #(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic starved
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (clr) begin
         cnt_next = '0;
      end else if (inc && (cnt_reg != MAX_CNT)) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign starved = (cnt_reg >= MAX_CNT);

endmodule

// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
// Shares the single instruction-memory port between fetch (read, highest
// priority), the microprogram loader (burst write, locks the port until its
// last beat) and the debug read port. A starvation counter bounds how long
// fetch may keep the loader/debug requesters waiting; when both of those are
// pending together, a round-robin bit picks between them.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   fe_req/fe_addr           fetch request and read address
//   fe_gnt/fe_rdata          fetch owns the port (comb) / read data (=imem_rdata)
//   ld_valid/ld_addr/ld_wdata/ld_last  loader beat
//   ld_ready                 beat written this cycle (comb)
//   dbg_req/dbg_addr         debug read request (held until ack)
//   dbg_ack/dbg_rdata        registered one-cycle ack and captured read data
//   code_modified            registered pulse after the last burst beat
//   imem_addr/imem_wdata/imem_we/imem_rdata  memory macro interface
// -----------------------------------------------------------------------------
module imem_port_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fe_req,
   input  logic [ADDR_W-1:0] fe_addr,
   output logic              fe_gnt,
   output logic [DATA_W-1:0] fe_rdata,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              code_modified,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              imem_we,
   input  logic [DATA_W-1:0] imem_rdata
);

   state_t            state_reg;
   state_t            state_next;
   logic              rr_reg;
   logic              rr_next;
   logic              dbg_ack_reg;
   logic [DATA_W-1:0] dbg_rdata_reg;
   logic              code_modified_reg;

   gnt_t              gnt;
   logic              ld_pend;
   logic              dbg_pend;
   logic              other_pend;
   logic              starved;
   logic              cnt_inc;
   logic              cnt_clr;

   imem_arb_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_ctr (
      .clk     (clk),
      .rst     (rst),
      .inc     (cnt_inc),
      .clr     (cnt_clr),
      .starved (starved)
   );

   // A debug request that is being acked this cycle has already been served;
   // treating it as pending would issue a second read for the same request.
   assign ld_pend    = ld_valid;
   assign dbg_pend   = dbg_req & ~dbg_ack_reg;
   assign other_pend = ld_pend | dbg_pend;

   // Next-state, grant selection and port muxing.
   always_comb begin
      gnt        = GNT_NONE;
      state_next = state_reg;
      rr_next    = rr_reg;
      cnt_inc    = 1'b0;
      cnt_clr    = 1'b0;

      unique case (state_reg)
         S_FETCH: begin
            if (fe_req && (!other_pend || !starved)) begin
               gnt     = GNT_FE;
               cnt_inc = other_pend;
               cnt_clr = ~other_pend;
            end else if (other_pend) begin
               cnt_clr = 1'b1;
               if (ld_pend && dbg_pend) begin
                  gnt     = rr_reg ? GNT_DBG : GNT_LD;
                  rr_next = ~rr_reg;
               end else if (ld_pend) begin
                  gnt = GNT_LD;
               end else begin
                  gnt = GNT_DBG;
               end
            end else begin
               cnt_clr = 1'b1;
            end
            if ((gnt == GNT_LD) && !ld_last) begin
               state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            // Burst owns the port: fetch and debug wait, gaps leave it idle.
            if (ld_valid) begin
               gnt     = GNT_LD;
               cnt_clr = 1'b1;
               if (ld_last) begin
                  state_next = S_FETCH;
               end
            end
         end
         default: begin
            state_next = S_FETCH;
         end
      endcase

      fe_gnt     = 1'b0;
      ld_ready   = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = fe_addr;
      imem_wdata = '0;
      unique case (gnt)
         GNT_FE: begin
            fe_gnt = 1'b1;
         end
         GNT_LD: begin
            ld_ready   = 1'b1;
            imem_we    = 1'b1;
            imem_addr  = ld_addr;
            imem_wdata = ld_wdata;
         end
         GNT_DBG: begin
            imem_addr = dbg_addr;
         end
         default: begin
         end
      endcase

      if (!rst) begin
         fe_gnt     = 1'b0;
         ld_ready   = 1'b0;
         imem_we    = 1'b0;
         imem_addr  = '0;
         imem_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg         <= S_FETCH;
         rr_reg            <= 1'b0;
         dbg_ack_reg       <= 1'b0;
         dbg_rdata_reg     <= '0;
         code_modified_reg <= 1'b0;
      end else begin
         state_reg         <= state_next;
         rr_reg            <= rr_next;
         dbg_ack_reg       <= (gnt == GNT_DBG);
         code_modified_reg <= (gnt == GNT_LD) && ld_last;
         if (gnt == GNT_DBG) begin
            dbg_rdata_reg <= imem_rdata;
         end
      end
   end

   assign fe_rdata      = imem_rdata;
   assign dbg_ack       = dbg_ack_reg;
   assign dbg_rdata     = dbg_rdata_reg;
   assign code_modified = code_modified_reg;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_port_arbiter
// Self-checking bench for imem_port_arbiter. Inputs change just after the
// falling edge and all outputs are sampled 1 time unit later, so each sample
// shows the combinational response to this cycle's inputs and the registered
// outputs produced by the previous rising edge. A 256-word memory model sits
// behind the imem port and is seeded with a fixed address pattern.
// -----------------------------------------------------------------------------
module tb_imem_port_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int MW = 4;

   logic          clk;
   logic          rst;
   logic          fe_req;
   logic [AW-1:0] fe_addr;
   logic          fe_gnt;
   logic [DW-1:0] fe_rdata;
   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          ld_last;
   logic          ld_ready;
   logic          dbg_req;
   logic [AW-1:0] dbg_addr;
   logic          dbg_ack;
   logic [DW-1:0] dbg_rdata;
   logic          code_modified;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_wdata;
   logic          imem_we;
   logic [DW-1:0] imem_rdata;

   logic [DW-1:0] mem [0:255];
   logic          mem_fill;

   int vectors     = 0;
   int miscompares = 0;

   imem_port_arbiter #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .MAX_WAIT (MW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fe_req        (fe_req),
      .fe_addr       (fe_addr),
      .fe_gnt        (fe_gnt),
      .fe_rdata      (fe_rdata),
      .ld_valid      (ld_valid),
      .ld_addr       (ld_addr),
      .ld_wdata      (ld_wdata),
      .ld_last       (ld_last),
      .ld_ready      (ld_ready),
      .dbg_req       (dbg_req),
      .dbg_addr      (dbg_addr),
      .dbg_ack       (dbg_ack),
      .dbg_rdata     (dbg_rdata),
      .code_modified (code_modified),
      .imem_addr     (imem_addr),
      .imem_wdata    (imem_wdata),
      .imem_we       (imem_we),
      .imem_rdata    (imem_rdata)
   );

   function automatic logic [DW-1:0] seed_word(input int a);
      logic [7:0] b;
      logic [7:0] t;
      b = a[7:0];
      t = b * 8'd3;
      return {b, ~b, 8'hA5, t};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (mem_fill) begin
         for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
      end else if (imem_we) begin
         mem[imem_addr] <= imem_wdata;
      end
   end

   assign imem_rdata = mem[imem_addr];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   task automatic drive_idle();
      fe_req   = 1'b0;
      fe_addr  = '0;
      ld_valid = 1'b0;
      ld_addr  = '0;
      ld_wdata = '0;
      ld_last  = 1'b0;
      dbg_req  = 1'b0;
      dbg_addr = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst      = 1'b0;
      fe_req   = 1'b1;
      fe_addr  = 8'h5A;
      ld_valid = 1'b1;
      ld_addr  = 8'h3C;
      ld_wdata = 32'h1234_5678;
      ld_last  = 1'b0;
      dbg_req  = 1'b1;
      dbg_addr = 8'h77;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         mem_fill = 1'b0;
         #1;
         vectors++;
         if ({fe_gnt, ld_ready, imem_we} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_grants cyc%0d: got %b required 000", i, {fe_gnt, ld_ready, imem_we});
         end
         vectors++;
         if ({dbg_ack, code_modified} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_regs cyc%0d: got %b required 00", i, {dbg_ack, code_modified});
         end
         vectors++;
         if (imem_addr !== 8'h00 || imem_wdata !== 32'h0 || dbg_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_bus cyc%0d: addr %h wdata %h dbg_rdata %h required zeros", i, imem_addr, imem_wdata, dbg_rdata);
         end
      end
      $display("test_reset: 2 reset cycles with all requests high");
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
   endtask

   task automatic test_starvation();
      apply_reset();
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         fe_req   = 1'b1;
         fe_addr  = 8'h10;
         dbg_req  = (c <= 6);
         dbg_addr = 8'h20;
         #1;
         if (c <= 4) begin
            vectors++;
            if (fe_gnt !== 1'b1 || imem_addr !== 8'h10 || imem_we !== 1'b0) begin
               miscompares++;
               $display("FAIL starve_fetch cyc%0d: gnt %b addr %h we %b required 1 10 0", c, fe_gnt, imem_addr, imem_we);
            end
         end else if (c == 5) begin
            vectors++;
            if (fe_gnt !== 1'b0 || imem_addr !== 8'h20 || imem_we !== 1'b0) begin
               miscompares++;
               $display("FAIL starve_dbg_grant cyc%0d: gnt %b addr %h we %b required 0 20 0", c, fe_gnt, imem_addr, imem_we);
            end
         end else if (c == 6) begin
            vectors++;
            if (dbg_ack !== 1'b1 || dbg_rdata !== seed_word(8'h20)) begin
               miscompares++;
               $display("FAIL starve_dbg_ack cyc%0d: ack %b data %h required 1 %h", c, dbg_ack, dbg_rdata, seed_word(8'h20));
            end
            vectors++;
            if (fe_gnt !== 1'b1) begin
               miscompares++;
               $display("FAIL starve_fetch_resume cyc%0d: gnt %b required 1", c, fe_gnt);
            end
         end else begin
            vectors++;
            if (dbg_ack !== 1'b0 || fe_gnt !== 1'b1) begin
               miscompares++;
               $display("FAIL starve_after cyc%0d: ack %b gnt %b required 0 1", c, dbg_ack, fe_gnt);
            end
         end
      end
      $display("test_starvation: debug read 20 after %0d fetch cycles -> %h", MW, dbg_rdata);
      drive_idle();
   endtask

   task automatic test_burst();
      logic [10:1] exp_fe;
      logic [10:1] exp_rdy;
      logic [10:1] exp_cm;
      logic [DW-1:0] bdata [3];
      int we_cnt;
      exp_fe  = 10'b1100001111;
      exp_rdy = 10'b0011010000;
      exp_cm  = 10'b0100000000;
      we_cnt  = 0;
      for (int i = 0; i < 3; i++) bdata[i] = $urandom;
      apply_reset();
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         fe_req   = 1'b1;
         fe_addr  = 8'h30;
         ld_valid = (c <= 5) || (c == 7) || (c == 8);
         ld_addr  = (c == 7) ? 8'h02 : ((c == 8) ? 8'h04 : 8'h00);
         ld_wdata = (c == 7) ? bdata[1] : ((c == 8) ? bdata[2] : bdata[0]);
         ld_last  = (c == 8);
         #1;
         if (imem_we === 1'b1) we_cnt++;
         vectors++;
         if (fe_gnt !== exp_fe[c] || ld_ready !== exp_rdy[c]) begin
            miscompares++;
            $display("FAIL burst_grant cyc%0d: fe_gnt %b ld_ready %b required %b %b", c, fe_gnt, ld_ready, exp_fe[c], exp_rdy[c]);
         end
         vectors++;
         if (code_modified !== exp_cm[c]) begin
            miscompares++;
            $display("FAIL burst_code_modified cyc%0d: got %b required %b", c, code_modified, exp_cm[c]);
         end
         if (exp_rdy[c]) begin
            vectors++;
            if (imem_we !== 1'b1 || imem_addr !== ld_addr || imem_wdata !== ld_wdata) begin
               miscompares++;
               $display("FAIL burst_write cyc%0d: we %b addr %h data %h required 1 %h %h", c, imem_we, imem_addr, imem_wdata, ld_addr, ld_wdata);
            end
            $display("test_burst: beat addr %h data %h", ld_addr, ld_wdata);
         end
      end
      vectors++;
      if (we_cnt != 3) begin
         miscompares++;
         $display("FAIL burst_we_count: got %0d required 3", we_cnt);
      end
      vectors++;
      if (mem[0] !== bdata[0] || mem[2] !== bdata[1] || mem[4] !== bdata[2]) begin
         miscompares++;
         $display("FAIL burst_mem: got %h %h %h required %h %h %h", mem[0], mem[2], mem[4], bdata[0], bdata[1], bdata[2]);
      end
      drive_idle();
   endtask

   task automatic test_simultaneous();
      logic [DW-1:0] wd;
      wd = $urandom;
      apply_reset();
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         fe_req   = 1'b0;
         ld_valid = (c == 1);
         ld_addr  = 8'h50;
         ld_wdata = wd;
         ld_last  = 1'b1;
         dbg_req  = (c <= 3);
         dbg_addr = 8'h60;
         #1;
         if (c == 1) begin
            vectors++;
            if (ld_ready !== 1'b1 || imem_we !== 1'b1 || imem_addr !== 8'h50 || fe_gnt !== 1'b0) begin
               miscompares++;
               $display("FAIL simul_ld_first: rdy %b we %b addr %h fe %b required 1 1 50 0", ld_ready, imem_we, imem_addr, fe_gnt);
            end
         end else if (c == 2) begin
            vectors++;
            if (imem_addr !== 8'h60 || imem_we !== 1'b0 || ld_ready !== 1'b0 || code_modified !== 1'b1) begin
               miscompares++;
               $display("FAIL simul_dbg_second: addr %h we %b rdy %b cm %b required 60 0 0 1", imem_addr, imem_we, ld_ready, code_modified);
            end
         end else if (c == 3) begin
            vectors++;
            if (dbg_ack !== 1'b1 || dbg_rdata !== seed_word(8'h60) || code_modified !== 1'b0) begin
               miscompares++;
               $display("FAIL simul_dbg_ack: ack %b data %h cm %b required 1 %h 0", dbg_ack, dbg_rdata, code_modified, seed_word(8'h60));
            end
         end else begin
            vectors++;
            if (dbg_ack !== 1'b0) begin
               miscompares++;
               $display("FAIL simul_ack_pulse: ack %b required 0", dbg_ack);
            end
         end
      end
      $display("test_simultaneous: loader 50 then debug 60 -> %h", dbg_rdata);
      drive_idle();
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         rst      = (c != 3);
         fe_req   = (c >= 2) && (c <= 4);
         fe_addr  = 8'h11;
         ld_valid = (c == 1);
         ld_addr  = 8'h70;
         ld_wdata = 32'hCAFE_0001;
         ld_last  = 1'b0;
         #1;
         vectors++;
         if (code_modified !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_no_pulse cyc%0d: cm %b required 0", c, code_modified);
         end
         if (c == 1) begin
            vectors++;
            if (ld_ready !== 1'b1) begin
               miscompares++;
               $display("FAIL midrst_beat1: rdy %b required 1", ld_ready);
            end
         end else if (c == 2 || c == 3) begin
            vectors++;
            if (fe_gnt !== 1'b0 || imem_we !== 1'b0) begin
               miscompares++;
               $display("FAIL midrst_locked cyc%0d: fe_gnt %b we %b required 0 0", c, fe_gnt, imem_we);
            end
         end else begin
            vectors++;
            if (fe_gnt !== fe_req || (fe_req && imem_addr !== 8'h11)) begin
               miscompares++;
               $display("FAIL midrst_recover cyc%0d: fe_gnt %b addr %h required %b 11", c, fe_gnt, imem_addr, fe_req);
            end
         end
      end
      $display("test_reset_mid_burst: burst abandoned, fetch resumed");
      drive_idle();
   endtask

   task automatic test_write_readback();
      apply_reset();
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         ld_valid = (c == 1);
         ld_addr  = 8'h44;
         ld_wdata = 32'hDEADBEEF;
         ld_last  = 1'b1;
         dbg_req  = (c == 2) || (c == 3);
         dbg_addr = 8'h44;
         #1;
         if (c == 1) begin
            vectors++;
            if (ld_ready !== 1'b1 || imem_we !== 1'b1) begin
               miscompares++;
               $display("FAIL wrrd_write: rdy %b we %b required 1 1", ld_ready, imem_we);
            end
         end else if (c == 2) begin
            vectors++;
            if (imem_addr !== 8'h44 || imem_we !== 1'b0) begin
               miscompares++;
               $display("FAIL wrrd_read_addr: addr %h we %b required 44 0", imem_addr, imem_we);
            end
         end else if (c == 3) begin
            vectors++;
            if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin
               miscompares++;
               $display("FAIL wrrd_data: ack %b data %h required 1 deadbeef", dbg_ack, dbg_rdata);
            end
         end else begin
            vectors++;
            if (dbg_ack !== 1'b0 || dbg_rdata !== 32'hDEADBEEF) begin
               miscompares++;
               $display("FAIL wrrd_hold: ack %b data %h required 0 deadbeef", dbg_ack, dbg_rdata);
            end
         end
      end
      $display("test_write_readback: 44 <- deadbeef, read back %h", dbg_rdata);
      drive_idle();
   endtask

   // Random traffic against a behavioural model of the arbitration rules:
   // fetch wins unless another requester has already been refused MW times;
   // loader vs debug alternates; a burst owns the port until its last beat.
   task automatic test_random();
      bit locked, pref_dbg, ack_now, cm_now, ld_taken;
      int waited, g;
      bit p_ld, p_dbg;
      logic [DW-1:0] dbg_model;
      logic [AW-1:0] exp_addr;
      locked    = 0;
      pref_dbg  = 0;
      ack_now   = 0;
      cm_now    = 0;
      ld_taken  = 0;
      waited    = 0;
      dbg_model = '0;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         fe_req  = ($urandom_range(0, 3) != 0);
         fe_addr = AW'($urandom);
         if (!ld_valid || ld_taken) begin
            ld_valid = ($urandom_range(0, 2) == 0);
            ld_addr  = AW'($urandom);
            ld_wdata = $urandom;
            ld_last  = ($urandom_range(0, 2) == 0);
         end
         if (ack_now) begin
            dbg_req = 1'b0;
         end else if (!dbg_req) begin
            dbg_req  = ($urandom_range(0, 3) == 0);
            dbg_addr = AW'($urandom);
         end
         #1;
         p_ld  = ld_valid;
         p_dbg = dbg_req && !ack_now;
         if (locked) g = p_ld ? 2 : 0;
         else if (fe_req && (!(p_ld || p_dbg) || waited < MW)) g = 1;
         else if (p_ld && p_dbg) g = pref_dbg ? 3 : 2;
         else if (p_ld) g = 2;
         else if (p_dbg) g = 3;
         else g = 0;
         exp_addr = (g == 2) ? ld_addr : ((g == 3) ? dbg_addr : fe_addr);

         vectors++;
         if (fe_gnt !== (g == 1) || ld_ready !== (g == 2) || imem_we !== (g == 2)) begin
            miscompares++;
            $display("FAIL rnd_grant cyc%0d: fe %b rdy %b we %b required grant %0d", c, fe_gnt, ld_ready, imem_we, g);
         end
         if (g != 0 || !locked) begin
            vectors++;
            if (imem_addr !== exp_addr) begin
               miscompares++;
               $display("FAIL rnd_addr cyc%0d: got %h required %h", c, imem_addr, exp_addr);
            end
         end
         vectors++;
         if (dbg_ack !== ack_now || code_modified !== cm_now || dbg_rdata !== dbg_model) begin
            miscompares++;
            $display("FAIL rnd_regs cyc%0d: ack %b cm %b data %h required %b %b %h", c, dbg_ack, code_modified, dbg_rdata, ack_now, cm_now, dbg_model);
         end
         vectors++;
         if (imem_we === 1'b1 && fe_gnt === 1'b1) begin
            miscompares++;
            $display("FAIL rnd_we_with_fetch cyc%0d: we %b fe_gnt %b", c, imem_we, fe_gnt);
         end
         if (g == 2) $display("rnd cyc%0d: loader write %h <- %h last %b", c, ld_addr, ld_wdata, ld_last);
         if (g == 3) $display("rnd cyc%0d: debug read %h", c, dbg_addr);

         // Model state after the coming rising edge.
         cm_now  = (g == 2) && ld_last;
         ack_now = (g == 3);
         if (g == 3) dbg_model = mem[dbg_addr];
         if (!locked && p_ld && p_dbg && g >= 2) pref_dbg = (g == 2);
         if (g == 1 && (p_ld || p_dbg)) waited = (waited < MW) ? waited + 1 : MW;
         else if (g >= 2 || !(p_ld || p_dbg)) waited = 0;
         if (g == 2) locked = !ld_last;
         ld_taken = (g == 2);
      end
      drive_idle();
   endtask

   initial begin
      rst      = 1'b0;
      mem_fill = 1'b1;
      drive_idle();
      test_reset();
      test_starvation();
      test_burst();
      test_simultaneous();
      test_reset_mid_burst();
      test_write_readback();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single instruction-memory port between three requesters: the fetch stage (read), the microprogram loader (burst write) and the debug read port.
- Fetch has priority. A starvation counter guarantees that the loader and debug requesters are eventually served.
- A loader burst locks the port until its last beat. Completion of a burst raises a one-cycle pulse that pipeline control uses as a flush.
- Sits between the fetch stage and the imem macro. Memory read data is combinational from the address.

Parameters:
- ADDR_W, 8, instruction-memory address width.
- DATA_W, 32, instruction word width.
- MAX_WAIT, 4, maximum number of consecutive cycles a pending loader or debug request may be denied by fetch.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset; state is reset on a posedge clk where rst==0.
- fe_req  in  1  fetch wants the port this cycle.
- fe_addr  in  ADDR_W  fetch read address.
- fe_gnt  out  1  fetch owns the port this cycle (combinational).
- fe_rdata  out  DATA_W  equals imem_rdata.
- ld_valid  in  1  loader beat valid.
- ld_addr  in  ADDR_W  loader write address.
- ld_wdata  in  DATA_W  loader write data.
- ld_last  in  1  final beat of the burst.
- ld_ready  out  1  beat accepted and written this cycle (combinational).
- dbg_req  in  1  debug read request; held until ack.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_ack  out  1  registered one-cycle ack.
- dbg_rdata  out  DATA_W  registered debug read data; valid while dbg_ack==1, holds its value otherwise.
- code_modified  out  1  registered pulse one cycle after the ld_last beat is accepted.
- imem_addr  out  ADDR_W  memory address.
- imem_wdata  out  DATA_W  memory write data.
- imem_we  out  1  memory write enable.
- imem_rdata  in  DATA_W  combinational read data.

Behaviour:
- States: S_FETCH (default) and S_LOAD (burst locked). Internal registers:
  - wait_cnt, width $clog2(MAX_WAIT+1).
  - rr, a round-robin bit; 0 means the loader is preferred next.
- Reset (rst==0 at posedge):
  - state=S_FETCH, wait_cnt=0, rr=0.
  - dbg_ack=0, dbg_rdata=0, code_modified=0.
  - While rst==0, combinational outputs are forced to fe_gnt=0, ld_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - Reset in the middle of a burst abandons the burst. No code_modified pulse is generated.
- S_FETCH per-cycle grant decision:
  - other_pend = ld_valid | (dbg_req & ~dbg_ack).
  - If fe_req and (~other_pend or wait_cnt<MAX_WAIT), fetch is granted: fe_gnt=1, imem_addr=fe_addr, imem_we=0.
  - Otherwise, if other_pend, one other requester is granted:
    - If both are pending, the winner is chosen by rr. rr is then updated to prefer the other requester.
    - If only one is pending, that one is granted.
  - Otherwise the port is idle: imem_addr=fe_addr, we=0, fe_gnt=0.
- Loader grant:
  - Drives imem_addr=ld_addr, imem_wdata=ld_wdata, imem_we=1, ld_ready=1.
  - If ld_last==0, the next state is S_LOAD. If ld_last==1, code_modified=1 on the next cycle.
- Debug grant:
  - Drives imem_addr=dbg_addr, imem_we=0.
  - At the clock edge, dbg_rdata<=imem_rdata and dbg_ack<=1, so data arrives with one-cycle latency.
  - A debug request is not re-granted while dbg_ack==1.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when fetch is granted while other_pend==1.
  - Clears when a loader or debug grant occurs, or when other_pend==0.
- S_LOAD:
  - fe_gnt=0, so fetch is stalled even when fe_req==1. Debug is also denied.
  - ld_ready=ld_valid. Gaps with ld_valid==0 leave the port idle with imem_we=0.
  - When ld_valid and ld_last are both 1: next state S_FETCH, code_modified=1 on the next cycle, wait_cnt=0.
- Simultaneous events:
  - A fetch request arriving in the same cycle as a starved request: the starved request wins.
  - When a debug request is pending while a burst is locked, the debug request is served first after the burst ends if rr points to debug. Otherwise it waits, and still has a wait bound of at most MAX_WAIT cycles once the state is back in S_FETCH.
- imem_we is never asserted in a cycle where fe_gnt==1.

Decomposition:
- Shared package imem_arb_pkg holds:
  - the state encoding enum (S_FETCH=1'b0, S_LOAD=1'b1);
  - the grant-select enum (GNT_NONE, GNT_FE, GNT_LD, GNT_DBG);
  - default ADDR_W and DATA_W constants.
- One natural sub-module: imem_arb_starve_ctr, which implements the saturating wait counter and its compare against MAX_WAIT.

Test Plan:
- Reset with rst=0 for 2 cycles, while fe_req=1, ld_valid=1 and dbg_req=1 -> fe_gnt=0, ld_ready=0, imem_we=0, dbg_ack=0, code_modified=0 throughout.
- fe_req=1 held, fe_addr=8'h10, dbg_req=1 with dbg_addr=8'h20, MAX_WAIT=4 -> fe_gnt=1 for 4 cycles; cycle 5 imem_addr=8'h20 and fe_gnt=0; cycle 6 dbg_ack=1 and dbg_rdata=mem[8'h20].
- Loader 3-beat burst to addresses 8'h00/8'h02/8'h04 with one idle gap, while fe_req=1 and fe_addr=8'h30 -> fe_gnt=0 from the first beat through the last; imem_we=1 exactly 3 cycles; code_modified=1 for one cycle after the last beat; fe_gnt=1 on the following cycle.
- fe_req=0, ld_valid=1 (single beat, ld_last=1) and dbg_req=1 in the same cycle -> loader granted first (rr=0); debug granted in the next cycle; dbg_ack=1 the cycle after that.
- rst=0 asserted during S_LOAD after beat 1 of a 3-beat burst -> state returns to S_FETCH, no code_modified pulse; after rst=1, fe_gnt follows fe_req.
- Write 32'hDEADBEEF to 8'h44 via the loader, then debug read of 8'h44 -> dbg_rdata=32'hDEADBEEF.
